// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of {pc, inst} pairs: circular buffer with flush and zeroed head when empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic [XLEN-1:0] push_inst,
    input  logic            pop,
    output logic            empty,
    output logic            full,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_inst
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);
    assign do_push   = push && !full && !flush;
    assign do_pop    = pop && !empty && !flush;
    assign head_pc   = empty ? '0 : pc_mem[rd_ptr];
    assign head_inst = empty ? '0 : inst_mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch PC generation, single-outstanding imem requests and prefetch queue to ID.
// Optional FETCH_BYPASS_EN forwards a response straight to ID when the queue is empty.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc,
    output fetch_state_t    dbg_state
);

    // Handshakes: imem_req/imem_addr stay stable until imem_ack (which may arrive
    // in the request cycle); an ID transfer happens when id_valid && id_ready.

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_nxt;
    logic [XLEN-1:0] drop_addr;
    logic [XLEN-1:0] drop_addr_nxt;
    logic            q_empty;
    logic            q_full;
    logic            q_push;
    logic            q_pop;
    logic            accept;
    logic            bypass;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_inst;

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = fetch_pc;
        if (state == DROP) begin
            imem_req  = !rst;
            imem_addr = drop_addr;
        end else begin
            imem_req  = !rst && !q_full;
        end
    end

    assign accept = (state == RUN) && imem_req && imem_ack && !redirect;

`ifdef FETCH_BYPASS_EN
    assign bypass = accept && q_empty;
`else
    assign bypass = 1'b0;
`endif

    assign q_push    = accept && !(bypass && id_ready);
    assign q_pop     = id_ready && !q_empty && !redirect;
    assign id_valid  = !q_empty || bypass;
    assign id_inst   = bypass ? imem_rdata : head_inst;
    assign id_pc     = bypass ? fetch_pc : head_pc;
    assign dbg_state = state;

    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        drop_addr_nxt = drop_addr;
        if (redirect) begin
            fetch_pc_nxt = word_align(redirect_pc);
            // An unanswered request must still be acked before the new stream starts.
            if (state == RUN && imem_req && !imem_ack) begin
                state_nxt     = DROP;
                drop_addr_nxt = imem_addr;
            end
        end else if (state == DROP) begin
            if (imem_ack) state_nxt = RUN;
        end else if (accept) begin
            fetch_pc_nxt = fetch_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            fetch_pc  <= RESET_PC;
            drop_addr <= RESET_PC;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            drop_addr <= drop_addr_nxt;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (q_push),
        .push_pc   (fetch_pc),
        .push_inst (imem_rdata),
        .pop       (q_pop),
        .empty     (q_empty),
        .full      (q_full),
        .head_pc   (head_pc),
        .head_inst (head_inst)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency-configurable memory model plus expected-queue scoreboard.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         redirect = 1'b0;
    logic [31:0]  redirect_pc = '0;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_ack;
    logic [31:0]  imem_rdata;
    logic         id_valid;
    logic         id_ready = 1'b0;
    logic [31:0]  id_inst;
    logic [31:0]  id_pc;
    fetch_state_t dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    int lat = 0;
    bit mem_en = 1'b0;
    int wait_cnt = 0;

    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return INST_NOP;
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory: acks once a request has been waiting lat cycles (lat 0 = same cycle).
    always @(posedge clk or posedge rst) begin
        if (rst)                        wait_cnt <= 0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                            wait_cnt <= 0;
    end

    always_comb begin
        imem_ack   = mem_en && imem_req && (wait_cnt >= lat);
        imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_q.push_back({pc, mem_word(pc)});
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        mem_en   = 1'b0;
        id_ready = 1'b0;
        redirect = 1'b0;
        tick();
        tick();
    endtask

    task automatic release_rst();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_sb_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_valid"}, 64'(id_valid), 64'd0);
    endtask

    // Scoreboard: every instruction accepted by ID must be the next expected one.
    always @(negedge clk) begin
        if (!rst && id_valid && id_ready && !redirect) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL sb_extra: observed pc %08h inst %08h expected none", id_pc, id_inst);
            end
            if (exp_q.size() != 0) check("sb_inst", {id_pc, id_inst}, exp_q.pop_front());
        end
    end

    // A pending request must keep its address until acked.
    always @(negedge clk) begin
        if (!rst && prev_hold && imem_req) check("addr_hold", 64'(imem_addr), 64'(prev_addr));
        prev_hold = !rst && imem_req && !imem_ack;
        prev_addr = imem_addr;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        mid();
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'(RESET_PC));
        check("rst_valid", 64'(id_valid), 64'd0);
        check("rst_inst", 64'(id_inst), 64'd0);
        check("rst_pc", 64'(id_pc), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(RUN));

        // Streaming at one instruction per cycle
        id_ready = 1'b1;
        lat      = 0;
        mem_en   = 1'b1;
        for (int i = 0; i < 5; i++) expect_pc(32'(4 * i));
        release_rst();
        for (int k = 0; k < 4; k++) begin
            mid();
            if (k == 0) begin
                check("t1_first_req", 64'(imem_req), 64'd1);
                check("t1_first_addr", 64'(imem_addr), 64'(RESET_PC));
            end
            check("t1_valid", 64'(id_valid), 64'((BYP != 0) || (k >= 1)));
            if ((BYP != 0) || (k >= 1)) begin
                check("t1_pc", 64'(id_pc), 64'(4 * (k - 1 + BYP)));
                if (k - 1 + BYP == 0) check("t1_inst0", 64'(id_inst), 64'h0050_0093);
                if (k - 1 + BYP == 1) check("t1_inst1", 64'(id_inst), 64'(INST_NOP));
            end
            tick();
        end
        tick();
        mem_en = 1'b0;
        mid();
        check("t1_tail_valid", 64'(id_valid), 64'(BYP == 0));
        repeat (3) tick();
        mid();
        check_drained("t1");

        // Queue fills with ID stalled, then one pop
        do_reset();
        lat    = 0;
        mem_en = 1'b1;
        for (int i = 0; i < 4; i++) expect_pc(32'(4 * i));
        release_rst();
        for (int k = 0; k < 4; k++) begin
            mid();
            check("t2_req", 64'(imem_req), 64'd1);
            check("t2_addr", 64'(imem_addr), 64'(4 * k));
            tick();
        end
        mid();
        check("t2_full_req", 64'(imem_req), 64'd0);
        check("t2_full_addr", 64'(imem_addr), 64'h10);
        check("t2_full_valid", 64'(id_valid), 64'd1);
        check("t2_full_pc", 64'(id_pc), 64'd0);
        tick();
        id_ready = 1'b1;
        mid();
        check("t2_pop_cycle_req", 64'(imem_req), 64'd0);
        tick();
        id_ready = 1'b0;
        mem_en   = 1'b0;
        mid();
        check("t2_rearm_req", 64'(imem_req), 64'd1);
        check("t2_rearm_addr", 64'(imem_addr), 64'h10);
        id_ready = 1'b1;
        repeat (4) tick();
        mid();
        check_drained("t2");

        // Reset while two entries are queued and a request waits
        do_reset();
        lat    = 0;
        mem_en = 1'b1;
        release_rst();
        tick();
        tick();
        mem_en = 1'b0;
        mid();
        check("t5_pre_valid", 64'(id_valid), 64'd1);
        check("t5_pre_addr", 64'(imem_addr), 64'h8);
        #1;
        rst = 1'b1;
        #1;
        check("t5_rst_valid", 64'(id_valid), 64'd0);
        check("t5_rst_req", 64'(imem_req), 64'd0);
        check("t5_rst_pc", 64'(id_pc), 64'd0);
        tick();
        expect_pc(RESET_PC);
        id_ready = 1'b1;
        mem_en   = 1'b1;
        release_rst();
        mid();
        check("t5_restart_req", 64'(imem_req), 64'd1);
        check("t5_restart_addr", 64'(imem_addr), 64'(RESET_PC));
        tick();
        mem_en = 1'b0;
        repeat (3) tick();
        mid();
        check_drained("t5");

        // Redirect together with an ack and a pop, two entries queued
        do_reset();
        lat    = 0;
        mem_en = 1'b1;
        release_rst();
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        id_ready    = 1'b1;
        expect_pc(32'h40);
        mid();
        check("t4_ack", 64'(imem_ack), 64'd1);
        check("t4_addr", 64'(imem_addr), 64'h8);
        check("t4_valid", 64'(id_valid), 64'd1);
        tick();
        redirect = 1'b0;
        mid();
        check("t4_post_valid", 64'(id_valid), 64'(BYP));
        check("t4_post_addr", 64'(imem_addr), 64'h40);
        check("t4_post_state", 64'(dbg_state), 64'(RUN));
        tick();
        mem_en = 1'b0;
        mid();
        check("t4_late_valid", 64'(id_valid), 64'(BYP == 0));
        repeat (3) tick();
        mid();
        check_drained("t4");

        // Slow memory: redirect while a request is pending
        do_reset();
        lat    = 3;
        mem_en = 1'b1;
        id_ready = 1'b1;
        expect_pc(32'h0);
        expect_pc(32'h4);
        release_rst();
        repeat (9) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        expect_pc(32'h100);
        mid();
        check("t3_pend_req", 64'(imem_req), 64'd1);
        check("t3_pend_addr", 64'(imem_addr), 64'h8);
        check("t3_pend_ack", 64'(imem_ack), 64'd0);
        tick();
        redirect = 1'b0;
        mid();
        check("t3_drop_state", 64'(dbg_state), 64'(DROP));
        check("t3_drop_addr", 64'(imem_addr), 64'h8);
        check("t3_drop_valid", 64'(id_valid), 64'd0);
        tick();
        mid();
        check("t3_drop_ack", 64'(imem_ack), 64'd1);
        check("t3_drop_ack_addr", 64'(imem_addr), 64'h8);
        check("t3_drop_ack_valid", 64'(id_valid), 64'd0);
        tick();
        mid();
        check("t3_run_state", 64'(dbg_state), 64'(RUN));
        check("t3_run_req", 64'(imem_req), 64'd1);
        check("t3_run_addr", 64'(imem_addr), 64'h100);
        check("t3_run_valid", 64'(id_valid), 64'd0);
        repeat (3) tick();
        mid();
        check("t3_ack_cycle_valid", 64'(id_valid), 64'(BYP));
        tick();
        mem_en = 1'b0;
        mid();
        check("t3_next_valid", 64'(id_valid), 64'(BYP == 0));
        repeat (3) tick();
        mid();
        check_drained("t3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end for the 5-stage pipeline. Generates the fetch PC and issues one-at-a-time requests to a variable-latency instruction memory. Buffers returned instructions in a small prefetch queue and presents them to the ID-stage pipeline register through a valid/ready handshake. On a redirect (taken branch or jump resolved at WB), it flushes the queue and restarts fetch at the new PC, discarding any response already in flight.

## Interface
- `DEPTH`, default 4: prefetch queue entries; power of two, at least 2.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `redirect`  in  1  flush the queue and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch PC; bits [1:0] are forced to 0.
- `imem_req`  out  1  request to instruction memory.
- `imem_addr`  out  32  word-aligned fetch address.
- `imem_ack`  in  1  `imem_rdata` is valid; completes the outstanding request.
- `imem_rdata`  in  32  returned instruction.
- `id_valid`  out  1  `id_inst`/`id_pc` hold a valid instruction.
- `id_ready`  in  1  ID stage accepts the instruction this cycle.
- `id_inst`  out  32  instruction at the queue head.
- `id_pc`  out  32  PC of `id_inst`.

## Operation
- Queue: circular buffer of {pc, inst} with `rd_ptr`/`wr_ptr` modulo DEPTH and `count` in 0..DEPTH.
  - push = accepted response; pop = `id_valid && id_ready`.
  - A push and a pop in the same cycle leave `count` unchanged.
- States:
  - RUN: `imem_req = (count < DEPTH)`, `imem_addr = fetch_pc`.
    - On `imem_ack`: push {fetch_pc, imem_rdata}, then `fetch_pc += 4` (wraps mod 2^32).
  - DROP: `imem_req = 1`, `imem_addr = drop_addr`, held stable.
    - On `imem_ack`: discard data and go to RUN.
- Redirect (highest priority):
  - Clear `count` and both pointers; `fetch_pc <= redirect_pc & ~3`.
  - Any `imem_ack` in the same cycle is discarded.
  - In RUN with `imem_req && !imem_ack`: capture `drop_addr = imem_addr` and go to DROP.
  - In DROP: stay in DROP and update `fetch_pc` only.
  - A pop in the same cycle is ignored.
- Request rules:
  - At most one request is outstanding.
  - While `imem_req` is high and `imem_ack` is low, `imem_addr` must not change.
  - The memory may assert `imem_ack` in the same cycle as `imem_req` (combinational memory).
- Outputs: `id_valid = (count != 0)`; `id_inst`/`id_pc` come from the queue head and are 0 when the queue is empty.
- Reset mid-operation: all state returns to its reset value immediately. An abandoned memory request is never re-acknowledged; the memory must tolerate this.

## Timing
- Reset values:
  - `imem_req` = 0 while `rst` is high.
  - `imem_addr` = RESET_PC.
  - `id_valid` = 0, `id_inst` = 0, `id_pc` = 0.
  - State = RUN, `fetch_pc` = RESET_PC.
- First cycle after `rst` deasserts: `imem_req` = 1, address RESET_PC.
- Latency, no bypass: `imem_ack` at edge N makes `id_valid` high in cycle N+1.
- Throughput: one instruction per cycle with single-cycle `imem_ack` and `id_ready` held high.
- Full queue (`count == DEPTH`): `imem_req` drops in that same cycle. It reasserts the cycle after a pop.
- Redirect in cycle N: `id_valid` = 0 in N+1.
  - In RUN: first request to `redirect_pc` is also in N+1.
  - In DROP: that request follows the DROP ack.

## Configuration
- `FETCH_BYPASS_EN`:
  - Defined: when in RUN with `count == 0` and `imem_ack` high (no redirect), `id_valid` = 1 in the same cycle, with `id_inst = imem_rdata` and `id_pc = fetch_pc`. If `id_ready` is also high, the entry is not pushed. Latency is 0 cycles.
  - Undefined: all responses go through the queue; latency is 1 cycle.

## Structure
- `fetch_pkg`:
  - `fetch_state_t` enum {RUN, DROP}.
  - `XLEN = 32`.
  - `INST_NOP = 32'h0000_0013`, shared with ID-stage bubble insertion.
- Sub-module `fetch_fifo` (parameter DEPTH): storage, pointers, count, flush input, push/pop, head outputs.
- `fetch_unit` itself holds the FSM, `fetch_pc`, `drop_addr`, and the bypass mux.

## Test plan
- Reset then single-cycle ack memory holding 0x00500093 at address 0, `id_ready` = 1 → `id_pc` takes 0, 4, 8 on consecutive cycles; `id_inst` at pc 0 = 0x00500093.
- `id_ready` = 0 with DEPTH = 4 → exactly 4 acks accepted, then `imem_req` = 0 with `imem_addr` = 0x10. One pop → `imem_req` = 1 the next cycle.
- 3-cycle ack latency, redirect to 0x103 while a request to 0x8 is pending → `imem_addr` stays 0x8 until ack; that data never reaches `id_valid`; next request is to 0x100.
- Redirect in the same cycle as an ack and a pop with `count` = 2 → `count` = 0 in the next cycle; next fetch is `redirect_pc`; the acked instruction is dropped.
- `rst` asserted mid-wait with 2 queued entries → `id_valid` = 0 and `imem_req` = 0 immediately; after release, the first request is to RESET_PC.
- With `FETCH_BYPASS_EN`, empty queue and an ack of 0x00000013 with `id_ready` = 1 → `id_valid` = 1 in the ack cycle and `count` stays 0.
